// File: rtl/reaction_game_sequencer.sv
// Reaction-timer trial controller: random arming delay, stimulus LED, tick-based
// reaction measurement, result classification and result-code handoff over valid/ready.
module reaction_game_sequencer #(
  parameter int unsigned CLK_DIV       = 10000,
  parameter int unsigned MIN_DELAY     = 1000,
  parameter int unsigned TIMEOUT_TICKS = 250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       button,
  output logic       led,
  output logic       busy,
  output logic [7:0] reaction_time,
  output logic [7:0] best_time,
  output logic       false_start,
  output logic       timed_out,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  input  logic       tx_ready,
  output logic [2:0] state
);

  localparam int unsigned   PW           = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST   = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PRESC_ZERO   = PW'(0);
  localparam logic [PW-1:0] PRESC_ONE    = PW'(1);
  localparam logic [7:0]    REACT_LAST   = 8'(TIMEOUT_TICKS - 1);
  localparam logic [16:0]   DELAY_BASE   = 17'(MIN_DELAY);
  localparam logic [7:0]    CODE_FALSE   = 8'hFE;
  localparam logic [7:0]    CODE_TIMEOUT = 8'hFF;
  localparam logic [7:0]    LFSR_SEED    = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARMED  = 3'd1,
    S_REACT  = 3'd2,
    S_REPORT = 3'd3
  } state_t;

  state_t        state_q, state_d;
  logic          btn_sync1_q, btn_sync2_q, btn_prev_q;
  logic [7:0]    lfsr_q, lfsr_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [16:0]   delay_q, delay_d;
  logic [7:0]    rcnt_q, rcnt_d;
  logic          led_q, led_d;
  logic          busy_q, busy_d;
  logic [7:0]    rt_q, rt_d;
  logic [7:0]    best_q, best_d;
  logic          fs_q, fs_d;
  logic          to_q, to_d;
  logic          tx_valid_q, tx_valid_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          press_s;
  logic          tick_s;

  // Right-shift Galois step for x^8+x^6+x^5+x^4+1.
  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    lfsr_next = {1'b0, cur[7:1]} ^ (cur[0] ? 8'hB8 : 8'h00);
  endfunction

  assign press_s = btn_sync2_q & ~btn_prev_q;
  assign tick_s  = (presc_q == PRESC_LAST);

  // Next-state and datapath logic for the trial sequencer.
  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_next(lfsr_q);
    presc_d    = tick_s ? PRESC_ZERO : (presc_q + PRESC_ONE);
    delay_d    = delay_q;
    rcnt_d     = rcnt_q;
    rt_d       = rt_q;
    best_d     = best_q;
    fs_d       = fs_q;
    to_d       = to_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ARMED;
          delay_d = DELAY_BASE + {7'd0, lfsr_q, 2'b00};
          presc_d = PRESC_ZERO;
          fs_d    = 1'b0;
          to_d    = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ARMED: begin
        if (press_s) begin
          state_d    = S_REPORT;
          fs_d       = 1'b1;
          tx_valid_d = 1'b1;
          tx_data_d  = CODE_FALSE;
        end else if (tick_s) begin
          delay_d = delay_q - 17'd1;
          if (delay_q == 17'd1) begin
            state_d = S_REACT;
            rcnt_d  = 8'd0;
            presc_d = PRESC_ZERO;
          end else begin
            state_d = S_ARMED;
          end
        end else begin
          state_d = S_ARMED;
        end
      end
      S_REACT: begin
        // A press on the timeout tick still reports the last full window.
        if (press_s) begin
          state_d    = S_REPORT;
          rt_d       = rcnt_q;
          tx_valid_d = 1'b1;
          tx_data_d  = rcnt_q;
          if (rcnt_q < best_q) begin
            best_d = rcnt_q;
          end else begin
            best_d = best_q;
          end
        end else if (tick_s) begin
          if (rcnt_q == REACT_LAST) begin
            state_d    = S_REPORT;
            to_d       = 1'b1;
            tx_valid_d = 1'b1;
            tx_data_d  = CODE_TIMEOUT;
          end else begin
            rcnt_d = rcnt_q + 8'd1;
          end
        end else begin
          state_d = S_REACT;
        end
      end
      S_REPORT: begin
        if (tx_valid_q && tx_ready) begin
          state_d    = S_IDLE;
          tx_valid_d = 1'b0;
        end else begin
          state_d = S_REPORT;
        end
      end
      default: begin
        state_d    = S_IDLE;
        tx_valid_d = 1'b0;
      end
    endcase

    led_d  = (state_d == S_REACT);
    busy_d = (state_d != S_IDLE);
  end

  // All state and registered outputs, with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      btn_sync1_q <= 1'b0;
      btn_sync2_q <= 1'b0;
      btn_prev_q  <= 1'b0;
      lfsr_q      <= LFSR_SEED;
      presc_q     <= PRESC_ZERO;
      delay_q     <= 17'd0;
      rcnt_q      <= 8'd0;
      led_q       <= 1'b0;
      busy_q      <= 1'b0;
      rt_q        <= 8'd0;
      best_q      <= 8'hFF;
      fs_q        <= 1'b0;
      to_q        <= 1'b0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      btn_sync1_q <= button;
      btn_sync2_q <= btn_sync1_q;
      btn_prev_q  <= btn_sync2_q;
      lfsr_q      <= lfsr_d;
      presc_q     <= presc_d;
      delay_q     <= delay_d;
      rcnt_q      <= rcnt_d;
      led_q       <= led_d;
      busy_q      <= busy_d;
      rt_q        <= rt_d;
      best_q      <= best_d;
      fs_q        <= fs_d;
      to_q        <= to_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
    end
  end

  assign led           = led_q;
  assign busy          = busy_q;
  assign reaction_time = rt_q;
  assign best_time     = best_q;
  assign false_start   = fs_q;
  assign timed_out     = to_q;
  assign tx_valid      = tx_valid_q;
  assign tx_data       = tx_data_q;
  assign state         = state_q;

endmodule

// File: doc/reaction_game_sequencer.md
# reaction_game_sequencer

Controller that sequences one reaction-timer trial: arms on a start request, waits a pseudo-random delay, lights the stimulus LED, measures button reaction in ticks, classifies the trial as valid / false start / timeout, and hands an 8-bit result code to the SPI driver over a valid/ready handshake. It sits between the board inputs and the existing timer, SPI and display blocks. It replaces the raw `led_on` input with a generated LED and supplies `reaction_time`. It also tracks the session best time.

## Interface
Parameters:
- `CLK_DIV`, 10000: clk cycles per tick (1 ms at 10 MHz); must be ≥ 2.
- `MIN_DELAY`, 1000: minimum ARMED delay in ticks (16-bit).
- `TIMEOUT_TICKS`, 250: reaction ticks before timeout; must be 1..250.

Ports:
- `clk`, in, 1: sole clock, rising edge.
- `reset`, in, 1: synchronous, active-high; clears all state.
- `start`, in, 1: trial request, sampled every cycle; a level held high counts once per IDLE visit.
- `button`, in, 1: raw pushbutton, asynchronous to `clk`.
- `led`, out, 1: stimulus LED, high only in REACT.
- `busy`, out, 1: high in every state except IDLE.
- `reaction_time`, out, 8: last valid result in ticks; holds between trials.
- `best_time`, out, 8: minimum valid result since reset; 8'hFF when none.
- `false_start`, out, 1: sticky flag for the last trial; cleared on the next trial accept.
- `timed_out`, out, 1: sticky flag for the last trial; cleared on the next trial accept.
- `tx_valid`, out, 1: result code offered to the SPI driver.
- `tx_data`, out, 8: result code; stable while `tx_valid` is high.
- `tx_ready`, in, 1: SPI driver accepts the code.
- `state`, out, 3: debug; IDLE=0, ARMED=1, REACT=2, REPORT=3.

## Operation
- Button path: 2-flop synchronizer, then rising-edge detect. `press` is a 1-cycle pulse, 3 cycles after the `button` rise.
- LFSR:
  - 8-bit Galois, polynomial x^8+x^6+x^5+x^4+1.
  - Seed 8'hA5 on reset; advances every cycle.
  - Its value is sampled on trial accept.
- Tick prescaler: counts 0..CLK_DIV-1, `tick` pulses on wrap. Forced to 0 on entry to ARMED and on entry to REACT, so every phase starts tick-aligned.
- IDLE:
  - `start`=1 accepts a trial.
  - delay counter ← MIN_DELAY + 4·lfsr (17-bit, no overflow).
  - Clear `false_start` and `timed_out`; go to ARMED.
- ARMED:
  - `press` → `false_start`=1, code 8'hFE, go to REPORT.
  - Else on `tick`, decrement the delay counter. The tick that makes it 0 → go to REACT, reaction counter ← 0.
  - If `press` and the final tick coincide, `press` wins (false start).
- REACT:
  - `press` → `reaction_time` ← counter, code ← counter; update `best_time` if counter < `best_time`; go to REPORT.
  - Else on `tick`, increment the counter. Reaching TIMEOUT_TICKS → `timed_out`=1, code 8'hFF, go to REPORT; `reaction_time` is unchanged.
  - If `press` and the timeout tick coincide, `press` wins and the captured value is TIMEOUT_TICKS−1.
- Result codes:
  - Valid results are 0..249.
  - 8'hFE = false start, 8'hFF = timeout.
  - Codes are never 8'hFE/8'hFF for valid results.
- REPORT:
  - `tx_valid`=1, `tx_data`=code.
  - On a cycle with `tx_valid`&`tx_ready` → IDLE, `tx_valid` drops the next cycle.
  - `press` and `start` are ignored here.
- `start` outside IDLE is ignored (no queuing).
- Reset mid-trial: immediate return to IDLE. All outputs go to reset values; no pending `tx_valid`.

## Timing
- Reset values:
  - `led`=0, `busy`=0, `state`=0.
  - `reaction_time`=0, `best_time`=8'hFF.
  - `false_start`=0, `timed_out`=0.
  - `tx_valid`=0, `tx_data`=0.
  - LFSR=8'hA5, prescaler=0.
- All outputs are registered.
- `state`, `led` and `busy` change on the edge that performs the transition.
- `start` high at edge N → ARMED visible after edge N.
- REACT entered at edge E; first tick at edge E+CLK_DIV. A reaction counter value k means the press arrived in the tick window [k, k+1).
- `press` at edge P → REPORT, `tx_valid`=1 and new `reaction_time`/`best_time` visible after edge P.
- Handshake:
  - `tx_ready` may be high before `tx_valid`; transfer completes on the first edge with both high.
  - Minimum REPORT residency is 1 cycle.
  - `tx_data` must not change while `tx_valid`=1.
- Trial-to-trial: IDLE lasts ≥1 cycle after REPORT, even with `start` held high.

## Test plan
All scenarios use CLK_DIV=4, MIN_DELAY=3, TIMEOUT_TICKS=10, with seed 8'hA5 giving a known ARMED length.
- Valid press:
  - Stimulus: `start` pulse, `button` rises 22 cycles after `led` rises, `tx_ready`=1.
  - Required: `reaction_time`=5, `tx_data`=8'h05 with a 1-cycle `tx_valid`, `best_time`=5, `led` low in REPORT.
- False start:
  - Stimulus: `button` rise while ARMED.
  - Required: `led` never rises, `false_start`=1, `tx_data`=8'hFE, `reaction_time` and `best_time` unchanged.
- Timeout:
  - Stimulus: no press.
  - Required: exactly 40 cycles after REACT entry → REPORT, `timed_out`=1, `tx_data`=8'hFF.
- Handshake back-pressure:
  - Stimulus: `tx_ready` held 0 for 7 cycles, then 1.
  - Required: `tx_valid` stays high with constant `tx_data`; IDLE one cycle after the transfer edge; `start` and `press` during REPORT are ignored.
- Best time and coincidence:
  - Stimulus: trials with results 7, then 3, then 9; then a press on the same edge as the timeout tick.
  - Required: `best_time` goes 7→3→3; the coincident trial returns 9, not 8'hFF.
- Reset mid-REACT:
  - Stimulus: assert `reset` for 1 cycle while `led`=1.
  - Required: next cycle `led`=0, `state`=0, `tx_valid`=0, `best_time`=8'hFF; the following `start` runs a normal trial.
